// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// The jump helper builds a J-type target from PC+4 and the 26-bit index field.
package mips_pkg;

  localparam int unsigned JIDX_W = 26;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HELD,
    S_DROP
  } fetch_state_e;

  function automatic logic [31:0] jump_addr(input logic [31:0] pc4,
                                            input logic [JIDX_W-1:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: instruction word, its PC+4 and a valid bit.
// Load wins over clear; a cleared entry always reads back as NOP.
module fetch_if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        clear_en,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (load_en) begin
      instr_d = load_instr;
      pc4_d   = load_pc4;
      valid_d = 1'b1;
    end else if (clear_en) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign pc_plus4    = pc4_q;
  assign instr_valid = valid_q;

endmodule

// File: rtl/etapa1_fetch.sv
// Instruction-fetch stage: owns the PC, issues one read at a time and fills IF/ID.
// state | meaning
// IDLE  | just out of reset, no request yet
// REQ   | ready to issue a read for pc when IF/ID can take it
// WAIT  | one read outstanding
// HELD  | response parked in the hold buffer until IF/ID frees up
// DROP  | wrong-path read outstanding, its data will be discarded
module etapa1_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_target,
  output logic [31:0]       instruction,
  output logic [31:0]       pc_plus4,
  output logic              instr_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc4_q, hold_pc4_d;

  logic        jump_taken;
  logic        ifid_free;
  logic        ifid_load;
  logic        ifid_clear;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [31:0] pc_inc;
  logic [31:0] target;

  assign jump_taken = jump & instr_valid & ~stall;
  assign ifid_free  = ~instr_valid | ~stall;
  assign pc_inc     = pc_q + INSTR_BYTES;
  assign target     = jump_addr(pc_plus4, jump_target);
  // A consumed entry empties unless a load refills it the same cycle.
  assign ifid_clear = jump_taken | (instr_valid & ~stall);
  assign imem_addr  = {pc_q[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    imem_req     = 1'b0;
    ifid_load    = 1'b0;
    ifid_instr   = imem_rdata;
    ifid_pc4     = pc_inc;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (jump_taken) begin
          pc_d = target;
        end else if (ifid_free) begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (jump_taken) begin
          pc_d    = target;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          pc_d = pc_inc;
          if (ifid_free) begin
            ifid_load = 1'b1;
            state_d   = S_REQ;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = pc_inc;
            state_d      = S_HELD;
          end
        end
      end
      S_HELD: begin
        if (jump_taken) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (ifid_free) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_instr_q;
          ifid_pc4   = hold_pc4_q;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  fetch_if_id_reg u_if_id (
    .clk         (clk),
    .reset       (reset),
    .load_en     (ifid_load),
    .clear_en    (ifid_clear),
    .load_instr  (ifid_instr),
    .load_pc4    (ifid_pc4),
    .instruction (instruction),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid)
  );

endmodule
